// File: rtl/merge_fifo_if.sv
// rtl/merge_fifo_if.sv - record enqueue/dequeue and status bundle for one merge-leg buffer
interface merge_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                  i_write;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_full;
    logic                  o_almost_full;
    logic                  i_read;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_empty;
    logic                  o_min_zero;
    logic [ADDR_WIDTH:0]   o_count;
    logic [ADDR_WIDTH:0]   o_runs;
    logic                  o_run_ready;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_write, i_data, i_read,
        input  o_full, o_almost_full, o_data, o_empty, o_min_zero,
               o_count, o_runs, o_run_ready, o_overflow, o_underflow
    );

    modport slave (
        input  i_write, i_data, i_read,
        output o_full, o_almost_full, o_data, o_empty, o_min_zero,
               o_count, o_runs, o_run_ready, o_overflow, o_underflow
    );
endinterface

// File: rtl/merge_fifo.sv
// rtl/merge_fifo.sv - FWFT input buffer for one merge-tree leg with run-terminator tracking
module merge_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    merge_fifo_if.slave   bus
);
    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_MARGIN);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic [ADDR_WIDTH:0] runs_q, runs_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic empty, full, wr, rd, wr_zero, rd_zero;
    logic [DATA_WIDTH-1:0] head;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign head    = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign wr      = bus.i_write & ~full;
    assign rd      = bus.i_read & ~empty;
    assign wr_zero = wr & (bus.i_data == '0);
    assign rd_zero = rd & (head == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        runs_d   = runs_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr && !rd) count_d = count_q + 1'b1;
        if (rd && !wr) count_d = count_q - 1'b1;
        if (wr_zero && !rd_zero) runs_d = runs_q + 1'b1;
        if (rd_zero && !wr_zero) runs_d = runs_q - 1'b1;
        if (bus.i_write && full) ovf_d = 1'b1;
        // A read colliding with a write into an empty buffer loses nothing: the record appears next cycle.
        if (bus.i_read && empty && !bus.i_write) unf_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            runs_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            runs_q   <= runs_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; reset still blocks the write so nothing lands mid-reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.i_data;
    end

    assign bus.o_data        = head;
    assign bus.o_empty       = empty;
    assign bus.o_full        = full;
    assign bus.o_almost_full = ((DEPTH_C - count_q) <= AF_C);
    assign bus.o_min_zero    = ~empty & (head == '0);
    assign bus.o_count       = count_q;
    assign bus.o_runs        = runs_q;
    assign bus.o_run_ready   = (runs_q != '0);
    assign bus.o_overflow    = ovf_q;
    assign bus.o_underflow   = unf_q;
endmodule

// File: tb/tb_merge_fifo.sv
// tb/tb_merge_fifo.sv - directed self-checking bench for merge_fifo
module tb_merge_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    merge_fifo_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus();

    merge_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_write = 1'b0;
        bus.i_read  = 1'b0;
        bus.i_data  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] v);
        bus.i_write = 1'b1; bus.i_read = 1'b0; bus.i_data = v;
        step();
        idle();
    endtask

    task automatic pop();
        bus.i_write = 1'b0; bus.i_read = 1'b1;
        step();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.o_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b exp=1", bus.o_empty); end
        total++; if (bus.o_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b exp=0", bus.o_full); end
        total++; if (bus.o_almost_full !== 1'b0) begin bad++; $display("FAIL rst_af got=%0b exp=0", bus.o_almost_full); end
        total++; if (bus.o_count !== 5'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.o_count); end
        total++; if (bus.o_runs !== 5'd0) begin bad++; $display("FAIL rst_runs got=%0d exp=0", bus.o_runs); end
        total++; if (bus.o_min_zero !== 1'b0) begin bad++; $display("FAIL rst_minzero got=%0b exp=0", bus.o_min_zero); end
        total++; if (bus.o_run_ready !== 1'b0) begin bad++; $display("FAIL rst_runready got=%0b exp=0", bus.o_run_ready); end
        total++; if (bus.o_overflow !== 1'b0 || bus.o_underflow !== 1'b0)
            begin bad++; $display("FAIL rst_sticky got=%0b%0b exp=00", bus.o_overflow, bus.o_underflow); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            push(32'(i));
            if (i == 13) begin
                total++; if (bus.o_almost_full !== 1'b0) begin bad++; $display("FAIL fill_af13 got=%0b exp=0", bus.o_almost_full); end
            end
            if (i == 14) begin
                total++; if (bus.o_almost_full !== 1'b1) begin bad++; $display("FAIL fill_af14 got=%0b exp=1", bus.o_almost_full); end
            end
            if (i == 15) begin
                total++; if (bus.o_full !== 1'b0) begin bad++; $display("FAIL fill_full15 got=%0b exp=0", bus.o_full); end
            end
        end
        total++; if (bus.o_full !== 1'b1) begin bad++; $display("FAIL fill_full got=%0b exp=1", bus.o_full); end
        total++; if (bus.o_count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d exp=16", bus.o_count); end
        total++; if (bus.o_data !== 32'd1) begin bad++; $display("FAIL fill_head got=%0d exp=1", bus.o_data); end
        total++; if (bus.o_overflow !== 1'b0) begin bad++; $display("FAIL fill_noovf got=%0b exp=0", bus.o_overflow); end
        push(32'd99);
        total++; if (bus.o_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", bus.o_overflow); end
        total++; if (bus.o_count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", bus.o_count); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            total++; if (bus.o_data !== 32'(i)) begin bad++; $display("FAIL drain_data%0d got=%0d exp=%0d", i, bus.o_data, i); end
            pop();
        end
        total++; if (bus.o_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", bus.o_empty); end
        total++; if (bus.o_underflow !== 1'b0) begin bad++; $display("FAIL drain_nounf got=%0b exp=0", bus.o_underflow); end
        pop();
        total++; if (bus.o_underflow !== 1'b1) begin bad++; $display("FAIL unf_set got=%0b exp=1", bus.o_underflow); end
        total++; if (bus.o_count !== 5'd0) begin bad++; $display("FAIL unf_count got=%0d exp=0", bus.o_count); end
    endtask

    task automatic test_runs();
        do_reset();
        push(32'd5); push(32'd7); push(32'd0); push(32'd3); push(32'd0);
        total++; if (bus.o_runs !== 5'd2) begin bad++; $display("FAIL runs_cnt got=%0d exp=2", bus.o_runs); end
        total++; if (bus.o_run_ready !== 1'b1) begin bad++; $display("FAIL runs_ready got=%0b exp=1", bus.o_run_ready); end
        total++; if (bus.o_min_zero !== 1'b0) begin bad++; $display("FAIL runs_mz_head5 got=%0b exp=0", bus.o_min_zero); end
        pop(); pop();
        total++; if (bus.o_min_zero !== 1'b1) begin bad++; $display("FAIL runs_mz_term got=%0b exp=1", bus.o_min_zero); end
        pop();
        total++; if (bus.o_runs !== 5'd1) begin bad++; $display("FAIL runs_after_rd got=%0d exp=1", bus.o_runs); end
        total++; if (bus.o_min_zero !== 1'b0) begin bad++; $display("FAIL runs_mz_head3 got=%0b exp=0", bus.o_min_zero); end
        total++; if (bus.o_data !== 32'd3) begin bad++; $display("FAIL runs_head got=%0d exp=3", bus.o_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) push(32'(100 + i));
        for (int i = 0; i < 20; i++) begin
            total++; if (bus.o_data !== 32'(100 + i)) begin bad++; $display("FAIL b2b_data%0d got=%0d exp=%0d", i, bus.o_data, 100 + i); end
            bus.i_write = 1'b1; bus.i_read = 1'b1; bus.i_data = 32'(108 + i);
            step();
            idle();
            total++; if (bus.o_count !== 5'd8) begin bad++; $display("FAIL b2b_count%0d got=%0d exp=8", i, bus.o_count); end
        end
        total++; if (bus.o_data !== 32'd120) begin bad++; $display("FAIL b2b_wrap_head got=%0d exp=120", bus.o_data); end
    endtask

    task automatic test_collisions();
        do_reset();
        for (int i = 0; i < 16; i++) push(32'(200 + i));
        bus.i_write = 1'b1; bus.i_read = 1'b1; bus.i_data = 32'd999;
        step();
        idle();
        total++; if (bus.o_count !== 5'd15) begin bad++; $display("FAIL col_full_count got=%0d exp=15", bus.o_count); end
        total++; if (bus.o_overflow !== 1'b1) begin bad++; $display("FAIL col_full_ovf got=%0b exp=1", bus.o_overflow); end
        for (int i = 1; i < 16; i++) begin
            total++; if (bus.o_data !== 32'(200 + i)) begin bad++; $display("FAIL col_drain%0d got=%0d exp=%0d", i, bus.o_data, 200 + i); end
            pop();
        end
        total++; if (bus.o_empty !== 1'b1) begin bad++; $display("FAIL col_drained got=%0b exp=1", bus.o_empty); end
        bus.i_write = 1'b1; bus.i_read = 1'b1; bus.i_data = 32'd0;
        step();
        idle();
        total++; if (bus.o_count !== 5'd1) begin bad++; $display("FAIL col_empty_count got=%0d exp=1", bus.o_count); end
        total++; if (bus.o_min_zero !== 1'b1) begin bad++; $display("FAIL col_empty_mz got=%0b exp=1", bus.o_min_zero); end
        total++; if (bus.o_underflow !== 1'b0) begin bad++; $display("FAIL col_empty_unf got=%0b exp=0", bus.o_underflow); end
        total++; if (bus.o_runs !== 5'd1) begin bad++; $display("FAIL col_empty_runs got=%0d exp=1", bus.o_runs); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] vals [9] = '{32'd1, 32'd0, 32'd2, 32'd0, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
        do_reset();
        for (int i = 0; i < 9; i++) push(vals[i]);
        total++; if (bus.o_count !== 5'd9 || bus.o_runs !== 5'd2)
            begin bad++; $display("FAIL mid_pre got=%0d/%0d exp=9/2", bus.o_count, bus.o_runs); end
        rst = 1'b1; bus.i_write = 1'b1; bus.i_data = 32'h55;
        step();
        rst = 1'b0;
        idle();
        total++; if (bus.o_count !== 5'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", bus.o_count); end
        total++; if (bus.o_runs !== 5'd0) begin bad++; $display("FAIL mid_runs got=%0d exp=0", bus.o_runs); end
        total++; if (bus.o_empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%0b exp=1", bus.o_empty); end
        step();
        total++; if (bus.o_count !== 5'd0 || bus.o_empty !== 1'b1)
            begin bad++; $display("FAIL mid_nostore got=%0d/%0b exp=0/1", bus.o_count, bus.o_empty); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_runs();
        test_back_to_back();
        test_collisions();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
